// File: rtl/cartoon_frame_writer.sv
// cartoon_frame_writer
//   Captures one active frame of the filtered 24-bit pixel stream into the ZBT
//   frame store. Each pixel is reduced to 3-3-2 RGB. Four pixels are packed into
//   one 36-bit word, and the word is offered on a single-entry request/grant port.
//   Optional build macro: ORDERED_DITHER_EN adds a 2x2 Bayer dither ahead of the
//   reduction. The default build uses plain truncation.
//
// Ports:
//   clk        system pixel clock
//   rst        synchronous active-high reset
//   hcount     horizontal raster count (leads rgb_in by PIX_DLY cycles)
//   vcount     vertical raster count   (leads rgb_in by PIX_DLY cycles)
//   rgb_in     filtered pixel {R,G,B}, 8 bits each
//   capture    one-cycle request to capture the next full frame
//   mem_grant  arbiter accepts the presented word this cycle
//   mem_req    word pending on mem_addr/mem_data
//   mem_addr   ZBT word address
//   mem_data   packed word {4'h0, slot0, slot1, slot2, slot3}
//   busy       high from capture accept until done
//   done       one-cycle pulse when the frame is fully written
//   overflow   sticky: a word was dropped during this capture
module cartoon_frame_writer #(
    parameter int PIX_DLY   = 1,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [23:0] rgb_in,
    input  logic        capture,
    input  logic        mem_grant,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    output logic [35:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [18:0] BASE   = 19'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, ARM, CAPT, FLUSH, DONE} state_t;
    state_t state;

    // Raster counters delayed so that hc/vc describe the pixel on rgb_in.
    logic [10:0] hc_dly [PIX_DLY];
    logic [9:0]  vc_dly [PIX_DLY];
    logic [10:0] hc;
    logic [9:0]  vc;

    assign hc = hc_dly[PIX_DLY-1];
    assign vc = vc_dly[PIX_DLY-1];

    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;
    logic [7:0] p;
    logic       unused_bits;

`ifdef ORDERED_DITHER_EN
    logic [1:0] d;
    logic [8:0] r_sum;
    logic [8:0] g_sum;
    logic [8:0] b_sum;

    always_comb begin
        case ({vc[0], hc[0]})
            2'b00:   d = 2'd0;
            2'b01:   d = 2'd2;
            2'b10:   d = 2'd3;
            default: d = 2'd1;
        endcase
        r_sum = {1'b0, rgb_in[23:16]} + {4'b0, d, 3'b0};
        g_sum = {1'b0, rgb_in[15:8]}  + {4'b0, d, 3'b0};
        b_sum = {1'b0, rgb_in[7:0]}   + {3'b0, d, 4'b0};
        // Carry out of the 8-bit add means the channel saturates at 255.
        r3 = r_sum[8] ? 3'b111 : r_sum[7:5];
        g3 = g_sum[8] ? 3'b111 : g_sum[7:5];
        b2 = b_sum[8] ? 2'b11  : b_sum[7:6];
    end

    // Low-order bits fall away in the 3-3-2 reduction.
    assign unused_bits = ^{r_sum[4:0], g_sum[4:0], b_sum[5:0]};
`else
    assign r3 = rgb_in[23:21];
    assign g3 = rgb_in[15:13];
    assign b2 = rgb_in[7:6];

    // Low-order bits fall away in the 3-3-2 reduction.
    assign unused_bits = ^{rgb_in[20:16], rgb_in[12:8], rgb_in[5:0]};
`endif

    assign p = {r3, g3, b2};

    logic        active;
    logic        frame_start;
    logic        frame_end;
    logic        take;
    logic        word_done;
    logic [23:0] pack;
    logic [18:0] word_cnt;

    assign active      = (hc < H_ACT) && (vc < V_ACT);
    assign frame_start = active && (hc == 11'd0) && (vc == 10'd0);
    assign frame_end   = active && (hc == H_LAST) && (vc == V_LAST);
    // The frame-start pixel is taken on the same cycle that ARM hands over to CAPT.
    assign take        = ((state == ARM) && frame_start) || ((state == CAPT) && active);
    assign word_done   = take && (hc[1:0] == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIX_DLY; i++) begin
                hc_dly[i] <= '0;
                vc_dly[i] <= '0;
            end
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            pack     <= '0;
            word_cnt <= '0;
        end else begin
            hc_dly[0] <= hcount;
            vc_dly[0] <= vcount;
            for (int i = 1; i < PIX_DLY; i++) begin
                hc_dly[i] <= hc_dly[i-1];
                vc_dly[i] <= vc_dly[i-1];
            end

            done <= 1'b0;

            if (take) begin
                case (hc[1:0])
                    2'd0:    pack[23:16] <= p;
                    2'd1:    pack[15:8]  <= p;
                    2'd2:    pack[7:0]   <= p;
                    default: ;
                endcase
            end

            // Single pending slot. A grant frees the slot in the same cycle, so a
            // word completing then replaces the old one. With no grant, the new
            // word is lost, but the address still advances so that the geometry
            // stays correct.
            if (word_done) begin
                word_cnt <= word_cnt + 19'd1;
                if (!mem_req || mem_grant) begin
                    mem_req  <= 1'b1;
                    mem_addr <= word_cnt;
                    mem_data <= {4'h0, pack, p};
                end else begin
                    overflow <= 1'b1;
                end
            end else if (mem_req && mem_grant) begin
                mem_req <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (capture) begin
                        state    <= ARM;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                ARM: begin
                    if (frame_start) begin
                        state    <= CAPT;
                        word_cnt <= BASE;
                    end
                end
                CAPT: begin
                    if (frame_end) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!mem_req || mem_grant) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cartoon_frame_writer.sv
module tb_cartoon_frame_writer;

    localparam int PIX_DLY   = 3;
    localparam int H_ACTIVE  = 16;
    localparam int V_ACTIVE  = 4;
    localparam int BASE_ADDR = 5;
    localparam int H_TOTAL   = 20;
    localparam int V_TOTAL   = 6;
    localparam int FRAME     = H_TOTAL * V_TOTAL;
    localparam int WPL       = H_ACTIVE / 4;

`ifdef ORDERED_DITHER_EN
    localparam int DITH = 1;
`else
    localparam int DITH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] rgb_in;
    logic        capture;
    logic        mem_grant;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [35:0] mem_data;
    logic        busy;
    logic        done;
    logic        overflow;

    always #5 clk = ~clk;

    cartoon_frame_writer #(
        .PIX_DLY  (PIX_DLY),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hcount   (hcount),
        .vcount   (vcount),
        .rgb_in   (rgb_in),
        .capture  (capture),
        .mem_grant(mem_grant),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    typedef struct packed {
        logic [3:0][23:0] px;
        logic [35:0]      word;
    } vec_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [35:0] data;
    } wr_t;

    vec_t tbl [8];
    wr_t  exp_q[$];
    wr_t  acc_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int idx = 0;
    int mode = 0;
    int hold = 0;
    int hold_cnt = 0;
    int done_cnt = 0;
    int n_acc = 0;
    bit sb_en = 1'b0;
    bit cap_next = 1'b0;
    bit m_armed = 1'b0;
    bit m_capt = 1'b0;
    bit pend_valid = 1'b0;
    wr_t pend;
    logic [7:0] m_pack [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b,
                                input logic [23:0] c, input logic [23:0] d,
                                input logic [35:0] w);
        vec_t v;
        v.px[0] = a;
        v.px[1] = b;
        v.px[2] = c;
        v.px[3] = d;
        v.word  = w;
        return v;
    endfunction

    function automatic logic [7:0] reduce(input logic [23:0] px, input int h, input int v);
        int r, g, b, d;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        d = (v % 2 == 0) ? ((h % 2 == 0) ? 0 : 2) : ((h % 2 == 0) ? 3 : 1);
        r = r + DITH * d * 8;
        g = g + DITH * d * 8;
        b = b + DITH * d * 16;
        if (r > 255) r = 255;
        if (g > 255) g = 255;
        if (b > 255) b = 255;
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

    function automatic logic [23:0] pixel(input int h, input int v);
        case (mode)
            0:       return 24'hFFFFFF;
            1:       return tbl[(v * WPL + h / 4) % 8].px[h % 4];
            2:       return 24'($urandom);
            default: return (h == 0 && v == 1) ? 24'h100000 : 24'h000000;
        endcase
    endfunction

    task automatic tick();
        int ph, pv, nidx;
        logic [23:0] px;
        logic [7:0] r;
        logic g;
        bit prev_req, prev_acc;
        logic [18:0] prev_addr;
        logic [35:0] prev_data;
        wr_t e, w;

        ph = idx % H_TOTAL;
        pv = idx / H_TOTAL;
        nidx = (idx + PIX_DLY) % FRAME;
        hcount = 11'(nidx % H_TOTAL);
        vcount = 10'(nidx / H_TOTAL);
        px = pixel(ph, pv);
        rgb_in = px;
        capture = cap_next;
        cap_next = 1'b0;

        if (mem_req === 1'b1) begin
            g = (hold_cnt >= hold);
            hold_cnt++;
        end else begin
            g = 1'b1;
        end
        mem_grant = g;

        if (mem_req === 1'b1 && g) begin
            n_acc++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_data), 64'(e.data));
                end
            end else begin
                w.addr = mem_addr;
                w.data = mem_data;
                acc_q.push_back(w);
            end
        end

        // Reference model of the capture window and packing.
        if (m_armed && ph == 0 && pv == 0) begin
            m_armed = 1'b0;
            m_capt  = 1'b1;
        end
        if (m_capt && ph < H_ACTIVE && pv < V_ACTIVE) begin
            r = reduce(px, ph, pv);
            if (ph % 4 != 3) begin
                m_pack[ph % 4] = r;
            end else begin
                w.addr = 19'(BASE_ADDR + pv * WPL + ph / 4);
                w.data = (mode == 1) ? tbl[(pv * WPL + ph / 4) % 8].word
                                     : {4'h0, m_pack[0], m_pack[1], m_pack[2], r};
                if (sb_en) begin
                    exp_q.push_back(w);
                    pend = w;
                    pend_valid = 1'b1;
                end
            end
            if (ph == H_ACTIVE - 1 && pv == V_ACTIVE - 1) m_capt = 1'b0;
        end
        if (capture && !m_armed && !m_capt && !busy) m_armed = 1'b1;

        prev_req  = (mem_req === 1'b1);
        prev_acc  = prev_req && g;
        prev_addr = mem_addr;
        prev_data = mem_data;

        @(posedge clk);
        #1;
        idx = (idx + 1) % FRAME;

        if (done === 1'b1) done_cnt++;
        if (pend_valid && !rst) begin
            check("req_1clk_after_pix3", 64'(mem_req), 64'd1);
            check("new_word_addr", 64'(mem_addr), 64'(pend.addr));
            check("new_word_data", 64'(mem_data), 64'(pend.data));
        end
        pend_valid = 1'b0;
        if (prev_req && !prev_acc && !rst) begin
            check("hold_stable", {8'h0, mem_req, mem_addr, mem_data},
                  {8'h0, 1'b1, prev_addr, prev_data});
        end
        if (mem_req && (prev_acc || !prev_req)) hold_cnt = 0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME && idx != target; i++) tick();
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3 * FRAME && done_cnt == d0; i++) tick();
        check({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        tick();
        check({name, "_done_width"}, 64'(done), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_req"}, 64'(mem_req), 64'd0);
        check({name, "_addr"}, 64'(mem_addr), 64'd0);
        check({name, "_data"}, 64'(mem_data), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_capt = 1'b0;
        pend_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, d0;

        tbl[0] = mk(24'hE00000, 24'h00E000, 24'h0000C0, 24'hFFFFFF, 36'h0E01C03FF);
        tbl[1] = mk(24'h000000, 24'h000000, 24'h000000, 24'h000000, 36'h000000000);
        tbl[2] = mk(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 36'h0FFFFFFFF);
        tbl[3] = mk(24'h200000, 24'h002000, 24'h000040, 24'h404080, 36'h02004014A);
        tbl[4] = mk(24'hA0C080, 24'h6020C0, 24'hE0E000, 24'h00E0C0, 36'h0BA67FC1F);
        tbl[5] = mk(24'h808080, 24'h406040, 24'hC0A000, 24'h20FF00, 36'h0924DD43C);
        tbl[6] = mk(24'hFF0000, 24'h0000FF, 24'h00FF00, 24'h606040, 36'h0E0031C6D);
        tbl[7] = mk(24'hC0C0C0, 24'h404040, 24'h80A040, 24'hE02080, 36'h0DB4995E6);

        rst = 1'b1;
        capture = 1'b0;
        mem_grant = 1'b1;
        hcount = '0;
        vcount = '0;
        rgb_in = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // All-white frame, grant always high, capture requested mid-frame.
        mode = 0; hold = 0; sb_en = 1'b1;
        run_to(50);
        a0 = n_acc;
        cap_next = 1'b1;
        tick();
        check("busy_after_capture", 64'(busy), 64'd1);
        wait_done("white");
        check("white_word_count", 64'(n_acc - a0), 64'(H_ACTIVE * V_ACTIVE / 4));
        check("white_sb_empty", 64'(exp_q.size()), 64'd0);
        check("white_overflow", 64'(overflow), 64'd0);

        // Table vectors, grant held low 3 clks per word, stray capture during CAPT.
        mode = 1; hold = 3;
        cap_next = 1'b1;
        tick();
        run_to(0);
        run_to(2 * H_TOTAL + 1);
        cap_next = 1'b1;
        tick();
        wait_done("table");
        check("table_sb_empty", 64'(exp_q.size()), 64'd0);
        check("table_overflow", 64'(overflow), 64'd0);
        d0 = done_cnt;
        repeat (FRAME) tick();
        check("stray_capture_no_done", 64'(done_cnt - d0), 64'd0);
        check("stray_capture_idle", 64'(busy), 64'd0);

        // Grant held low 5 clks: every other word is dropped.
        mode = 2; hold = 5; sb_en = 1'b0;
        acc_q.delete();
        cap_next = 1'b1;
        tick();
        wait_done("drop");
        check("drop_overflow", 64'(overflow), 64'd1);
        check("drop_some_written", 64'(acc_q.size() >= 2), 64'd1);
        if (acc_q.size() >= 2) begin
            check("drop_first_addr", 64'(acc_q[0].addr), 64'(BASE_ADDR));
            check("drop_second_addr", 64'(acc_q[1].addr), 64'(BASE_ADDR + 2));
        end
        repeat (5) tick();
        check("overflow_sticky", 64'(overflow), 64'd1);

        // New capture clears overflow; reset mid-frame abandons it.
        hold = 0; sb_en = 1'b1;
        model_reset();
        cap_next = 1'b1;
        tick();
        check("capture_clears_ovf", 64'(overflow), 64'd0);
        check("capture_sets_busy", 64'(busy), 64'd1);
        run_to(0);
        run_to(2 * H_TOTAL + 5);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        model_reset();
        repeat (2 * FRAME) tick();
        check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        check("midreset_idle", 64'(busy), 64'd0);
        cap_next = 1'b1;
        tick();
        wait_done("restart");
        check("restart_sb_empty", 64'(exp_q.size()), 64'd0);

        // Single bright-red probe at (hc=0, vc=1): dither decides the reduced R.
        mode = 3; sb_en = 1'b0;
        acc_q.delete();
        cap_next = 1'b1;
        tick();
        wait_done("probe");
        check("probe_word_count", 64'(acc_q.size()), 64'(H_ACTIVE * V_ACTIVE / 4));
        if (acc_q.size() > 4) begin
            check("probe_addr", 64'(acc_q[4].addr), 64'(BASE_ADDR + WPL));
            check("probe_data", 64'(acc_q[4].data), (DITH == 1) ? 64'h020000000 : 64'h0);
            check("probe_line0", 64'(acc_q[0].data), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cartoon_frame_writer.md
Name: cartoon_frame_writer

Overview:
- Takes the filtered 24-bit pixel stream from the cartoon/edge filter, together with the raster counters, and captures exactly one active frame into the ZBT frame store on request.
- Each pixel is reduced to 3-3-2 RGB; four pixels are packed into one 36-bit memory word.
- Words are written through a request/grant port shared with the display reader.
- Sits between the filter output mux and the ZBT arbiter.

Parameters:
- PIX_DLY, 1: cycles between hcount/vcount and the matching rgb_in pixel; internal coordinate delay; must be >= 1.
- H_ACTIVE, 640: active pixels per line; must be a multiple of 4.
- V_ACTIVE, 480: active lines per frame.
- BASE_ADDR, 0: word address of pixel (0,0).

Ports:
- clk  in  1  system pixel clock
- rst  in  1  synchronous active-high reset
- hcount  in  11  horizontal raster count
- vcount  in  10  vertical raster count
- rgb_in  in  24  filtered pixel {R,G,B}, 8 bits each
- capture  in  1  one-cycle request to capture the next full frame
- mem_grant  in  1  arbiter accepts the presented word this cycle
- mem_req  out  1  word pending on mem_addr/mem_data
- mem_addr  out  19  ZBT word address
- mem_data  out  36  packed word
- busy  out  1  high from capture accept until done
- done  out  1  one-cycle pulse when the frame is fully written
- overflow  out  1  sticky: a word was dropped during this capture

Behaviour:
- Reset: one clock and one synchronous active-high reset, named clk and rst. On rst, all outputs go to 0, the FSM goes to IDLE, and the pack and pending registers clear. Reset mid-capture abandons the frame with no done pulse.
- Coordinate alignment: hc/vc are hcount/vcount delayed PIX_DLY cycles.
  - A pixel is active when hc < H_ACTIVE and vc < V_ACTIVE.
  - Frame start is the active pixel with hc == 0 and vc == 0.
  - Frame end is the active pixel with hc == H_ACTIVE-1 and vc == V_ACTIVE-1.
- Pixel reduction: p = {R[7:5], G[7:5], B[7:6]}.
- Packing: the slot is hc[1:0]. Slot 0 goes to pack[31:24], slot 1 to [23:16], slot 2 to [15:8], slot 3 to [7:0]. Word bits [35:32] are 0.
  - On a slot-3 active pixel, the word {4'h0, pack[31:8], p} is complete that cycle.
  - It is presented on mem_data the next cycle, so latency is 1 clk from the 4th pixel to mem_req.
- Addressing:
  - The word counter loads BASE_ADDR at frame start.
  - It increments after every completed word, including dropped words, so image geometry is preserved.
  - Word n goes to BASE_ADDR + vc*(H_ACTIVE/4) + hc/4.
- Handshake:
  - mem_req, mem_addr and mem_data are held stable until a cycle with mem_req && mem_grant. mem_req falls the following cycle unless a new word loads in the same cycle.
  - One pending slot only. If a word completes while mem_req is high and mem_grant is low, the new word is dropped and overflow is set. overflow is sticky until the next accepted capture.
  - If the grant and a completion coincide, the new word replaces the old one with no overflow.
- FSM:
  - IDLE: busy = 0. capture moves to ARM and clears overflow.
  - ARM: busy = 1. Waits for frame start; the frame-start pixel is captured in the same cycle the FSM enters CAPT.
  - CAPT: packs and writes active pixels. At frame end goes to FLUSH.
  - FLUSH: waits until the last word is granted, then goes to DONE.
  - DONE: done = 1 for one cycle, busy = 0, then returns to IDLE.
  - capture while not in IDLE is ignored.
- Blanking pixels never write and never advance the counter.

Optional Feature:
- Macro: ORDERED_DITHER_EN.
- When defined, a 2x2 Bayer dither is applied before reduction.
  - d = {0,2,3,1} indexed by {vc[0], hc[0]}.
  - R' = sat255(R + (d<<3)), G' = sat255(G + (d<<3)), B' = sat255(B + (d<<4)).
- When undefined, plain truncation is used.
- Latency is unchanged either way; the dither is combinational within the same stage.

Test Plan:
- Basic write: PIX_DLY=1, mem_grant tied 1, capture pulsed mid-frame, rgb_in = 24'hFFFFFF everywhere -> writing starts at the next frame start. Exactly 76800 writes occur, addresses 0..76799, every data word is 36'h0FFFFFFFF, then one done pulse with busy low after it.
- Packing order: line 0 pixels 0..3 = 24'hE0_00_00, 24'h00_E0_00, 24'h00_00_C0, 24'hFF_FF_FF -> word at addr 0 = 36'h0E01C03FF, with mem_req asserted 1 clk after pixel 3.
- Grant backpressure: mem_grant held 0 for 3 clks after a word, next word 4 clks later -> data held stable, write succeeds, overflow = 0. With mem_grant held 0 for 5 clks -> second word dropped, overflow = 1, next address still +2 from the first.
- Control edges: capture during CAPT -> ignored, single done. rst asserted at line 100 -> all outputs 0 next clk and no done. A new capture then restarts from address BASE_ADDR.
- PIX_DLY=4, pixel value set only at raw hcount = 4 (aligned hc = 0) -> it lands in slot 0 of word 0, i.e. alignment uses the delayed counters.
- ORDERED_DITHER_EN defined, R = 8'h10 at (hc=0, vc=1) -> d = 3, R' = 8'h28, reduced R = 3'b001. Without the macro, reduced R = 3'b000.
